// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer: state encoding, default width and latency bounds.
// The optional branch path is enabled by defining PC_SEQ_BRANCH_EN.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } pc_state_e;

    localparam int PC_SEQ_ADDR_W  = 5;
    localparam int PC_SEQ_LAT_MIN = 1;
    localparam int PC_SEQ_LAT_MAX = 15;
    localparam int PC_SEQ_CNT_W   = 4;

    // Out-of-range latencies are pulled into the legal window so the wait counter stays in range.
    function automatic int clamp_lat(input int lat);
        if (lat < PC_SEQ_LAT_MIN) return PC_SEQ_LAT_MIN;
        if (lat > PC_SEQ_LAT_MAX) return PC_SEQ_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/pc_branch_latch.sv
// Holds a pending branch request and its target until the sequencer consumes it on a PC write.
// Only instantiated when PC_SEQ_BRANCH_EN is defined.
module pc_branch_latch
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = PC_SEQ_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_target,
    input  logic              consume,
    output logic              pending,
    output logic [ADDR_W-1:0] target
);

    // A new request outranks the consume of the old one, so a request on the
    // write edge survives into the following update; later requests overwrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            target  <= '0;
        end else if (req) begin
            pending <= 1'b1;
            target  <= req_target;
        end else if (consume) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: FETCH -> WAIT x FETCH_LAT -> UPDATE, driving PCNext/PCWrite to the ProgramCounter.
// Define PC_SEQ_BRANCH_EN to include the branch latch and target mux.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = PC_SEQ_ADDR_W,
    parameter int FETCH_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCResult,
    input  logic              BranchReq,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Stall,
    input  logic              Halt,
    output logic [ADDR_W-1:0] PCNext,
    output logic              PCWrite,
    output logic              FetchValid,
    output logic [ADDR_W-1:0] FetchAddr,
    output logic [1:0]        State
);

    localparam int LAT = clamp_lat(FETCH_LAT);
    localparam logic [PC_SEQ_CNT_W-1:0] LAT_LAST = PC_SEQ_CNT_W'(LAT - 1);

    pc_state_e               state, state_next;
    logic                    halted, halted_next;
    logic [PC_SEQ_CNT_W-1:0] count, count_next;
    logic [ADDR_W-1:0]       addr_reg, next_reg, next_pc;
    logic                    pending;
    logic [ADDR_W-1:0]       target_reg;
    logic                    write_now;

`ifdef PC_SEQ_BRANCH_EN
    pc_branch_latch #(.ADDR_W(ADDR_W)) u_branch (
        .clk        (Clk),
        .rst        (Reset),
        .req        (BranchReq),
        .req_target (BranchTarget),
        .consume    (write_now),
        .pending    (pending),
        .target     (target_reg)
    );
`else
    logic unused_branch;
    assign unused_branch = ^{BranchReq, BranchTarget};
    assign pending       = 1'b0;
    assign target_reg    = '0;
`endif

    // Sequential increment wraps modulo 2^ADDR_W.
    assign next_pc = pending ? target_reg : addr_reg + ADDR_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            halted   <= 1'b0;
            count    <= '0;
            addr_reg <= '0;
            next_reg <= '0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
            count  <= count_next;
            if (state == FETCH)  addr_reg <= PCResult;
            if (state == UPDATE) next_reg <= next_pc;
        end
    end

    always_comb begin
        state_next  = state;
        halted_next = halted;
        count_next  = count;
        write_now   = 1'b0;
        case (state)
            IDLE: begin
                if (!halted) state_next = FETCH;
            end
            FETCH: begin
                count_next = LAT_LAST;
                state_next = WAIT;
            end
            WAIT: begin
                if (!Stall) begin
                    if (count == '0) state_next = UPDATE;
                    else             count_next = count - PC_SEQ_CNT_W'(1);
                end
            end
            UPDATE: begin
                if (!Stall) begin
                    write_now = 1'b1;
                    if (Halt) begin
                        state_next  = IDLE;
                        halted_next = 1'b1;
                    end else begin
                        state_next  = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FetchValid/FetchAddr form a one-cycle valid strobe with no ready: memory
    // always accepts and its data is assumed back after FETCH_LAT wait cycles.
    assign FetchValid = (state == FETCH);
    assign FetchAddr  = FetchValid ? PCResult : '0;
    assign PCWrite    = write_now;
    assign PCNext     = (state == UPDATE) ? next_pc : next_reg;
    assign State      = state;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer that drives the program counter's update side. Each instruction it reads the current PC value (PCResult), issues a fetch address with a valid strobe, waits a fixed memory latency, then presents PCNext and pulses PCWrite for one cycle. PCNext is either the sequential address (PC+1) or a latched branch target. Sits between the ProgramCounter register and instruction memory, and owns all PCWrite/PCNext traffic.

## Interface
- ADDR_W, 5, width of PC and all address ports
- FETCH_LAT, 2, number of WAIT cycles per fetch; legal range 1..15
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high
- PCResult  input  ADDR_W  current PC from ProgramCounter
- BranchReq  input  1  single-cycle branch request
- BranchTarget  input  ADDR_W  target, sampled when BranchReq=1
- Stall  input  1  freezes WAIT counter and blocks PCWrite
- Halt  input  1  level; stops sequencing after the current update
- PCNext  output  ADDR_W  next PC value to ProgramCounter
- PCWrite  output  1  PC load strobe
- FetchValid  output  1  fetch address valid
- FetchAddr  output  ADDR_W  instruction memory address
- State  output  2  current FSM state (debug)

## Operation
- States: IDLE=0, FETCH=1, WAIT=2, UPDATE=3. HALTED is encoded as IDLE with the internal halted flag set.
- IDLE (not halted) always goes to FETCH on the next edge.
- FETCH (1 cycle):
  - FetchValid=1, FetchAddr=PCResult (combinational).
  - AddrReg<=PCResult.
  - Counter<=FETCH_LAT-1.
  - Goes to WAIT.
- WAIT:
  - If Stall=0, counter decrements. When counter=0 and Stall=0, goes to UPDATE.
  - If Stall=1, counter and state hold.
- UPDATE:
  - PCNext = Pending ? TargetReg : AddrReg+1. The add is modulo 2^ADDR_W, so 31 wraps to 0.
  - PCWrite = !Stall.
  - If Stall=1, the block holds in UPDATE and PCNext stays stable.
  - On the write edge:
    - Pending clears.
    - Next state is HALTED if Halt=1, otherwise FETCH.
- Branch latch:
  - BranchReq=1 in any state sets Pending and loads TargetReg<=BranchTarget.
  - If a second request arrives while Pending is set, it overwrites TargetReg (latest wins).
  - If BranchReq coincides with the UPDATE write edge, the new request is kept (Pending stays 1 with the new target) and applies to the next update. The current update uses the old value.
- HALTED: FetchValid=0 and PCWrite=0 permanently. The only exit is Reset.
- Outputs outside FETCH/UPDATE: FetchValid=0, PCWrite=0, PCNext holds its last computed value.

## Timing
- Reset values (immediate, asynchronous):
  - State=IDLE, halted flag=0, Pending=0.
  - TargetReg=0, AddrReg=0, Counter=0.
  - PCNext=0, PCWrite=0, FetchValid=0, FetchAddr=0.
- Reset asserted mid-operation aborts the update. No PCWrite is issued in the reset cycle or the cycle after release.
- Without stalls, one instruction takes FETCH_LAT+2 cycles, with PCWrite high in the last of them.
- First PCWrite after reset release comes on cycle FETCH_LAT+3 (IDLE, FETCH, WAIT×FETCH_LAT, UPDATE).
- Each stalled cycle adds exactly one cycle. PCWrite is never high for more than one consecutive cycle.
- Branch latency: a BranchReq accepted before the UPDATE write edge takes effect at that UPDATE.

## Configuration
- PC_SEQ_BRANCH_EN defined: branch latch and target mux are present, as described above.
- PC_SEQ_BRANCH_EN undefined:
  - Ports BranchReq and BranchTarget still exist but are ignored.
  - Pending is tied 0 and PCNext is always AddrReg+1.
  - No TargetReg flops are synthesised.

## Structure
- Shared package pc_seq_pkg holds:
  - state encoding constants (IDLE, FETCH, WAIT, UPDATE);
  - default ADDR_W;
  - FETCH_LAT bounds.
- One sub-module, pc_branch_latch, holds Pending and TargetReg plus the set/clear/overwrite priority. It is instantiated only under PC_SEQ_BRANCH_EN.
- The FSM, counter and increment stay in pc_sequencer.

## Test plan
- Reset 20 ns, then release with PCResult=0, FETCH_LAT=2 -> PCWrite high only in cycle 5 after release, with PCNext=1. FetchValid high in cycle 2 with FetchAddr=0.
- Wrap: PCResult=31 -> PCNext=0 on the UPDATE cycle, PCWrite=1.
- Branch: PCResult=4, BranchReq pulse with BranchTarget=12 during WAIT -> PCNext=12. On the following instruction (PCResult=12), PCNext=13.
- Stall held for 3 cycles entering UPDATE with PCResult=7 -> PCWrite=0 for those 3 cycles with PCNext=8 stable, then exactly one cycle with PCWrite=1.
- Halt=1 during an UPDATE write -> that write occurs, then FetchValid=0 and PCWrite=0 for 20 cycles. Reset restarts normal fetch.
- Reset asserted during WAIT, and separately BranchReq on the UPDATE write edge (target 20, old pending target 9) -> all outputs 0 immediately; PCNext=9 now and 20 at the next update.
